// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction-fetch / data-memory arbiter.
//   - STARVE_LIMIT_DEF : default number of consecutive fetch-lost cycles
//                        before fetch is forced to win arbitration.
//   - ADDR_W / DATA_W  : shared memory address and data widths.
//   - resp_state_t     : response tracking FSM encoding.
//   - is_misaligned()  : word-alignment check on a byte address.
package mem_arb_pkg;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_DM = 2'd2
  } resp_state_t;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating starvation counter for the fetch port.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset, clears the count
//   inc      in   fetch lost this cycle (request pending, not granted)
//   clr      in   fetch granted this cycle; has priority over inc
//   at_limit out  count has reached LIMIT (fetch must win next)
module starve_counter #(
  parameter int LIMIT = 4,
  parameter int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [CNT_W-1:0] count;

  assign at_limit = (count >= CNT_W'(LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-cycle-latency memory between an
// instruction-fetch port and a data port. Data normally wins; fetch is
// forced through once it has lost STARVE_LIMIT consecutive cycles.
// Misaligned data requests are rejected with a one-cycle dm_err pulse.
// Ports:
//   clk, rst                      clock / async active-high reset
//   if_req, if_addr               fetch request and byte address
//   if_gnt, if_rvalid, if_rdata   fetch accept and read response
//   dm_req, dm_we, dm_addr,       data request (store when dm_we=1)
//   dm_wdata
//   dm_gnt, dm_rvalid, dm_rdata   data accept and load response
//   dm_err                        misaligned data request rejected
//   mem_addr, mem_wd, mem_we      shared memory command (this cycle)
//   mem_rd                        shared memory read data (next cycle)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
);

  resp_state_t resp_state;
  resp_state_t resp_state_next;
  logic        fetch_at_limit;

  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (if_req && !if_gnt),
    .clr      (if_gnt),
    .at_limit (fetch_at_limit)
  );

  // Stage boundary: the response owner is registered at the grant edge;
  // memory read data arrives during the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_state <= IDLE;
    end else begin
      resp_state <= resp_state_next;
    end
  end

  // Arbitration, memory command and response steering. Everything is
  // forced to zero while reset is held so no output leaks a pending request.
  always_comb begin
    resp_state_next = IDLE;
    if_gnt          = 1'b0;
    dm_gnt          = 1'b0;
    dm_err          = 1'b0;
    mem_addr        = '0;
    mem_wd          = '0;
    mem_we          = 1'b0;
    if_rvalid       = 1'b0;
    dm_rvalid       = 1'b0;
    if_rdata        = '0;
    dm_rdata        = '0;

    if (!rst) begin
      case (resp_state)
        RESP_IF: begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rd;
        end
        RESP_DM: begin
          dm_rvalid = 1'b1;
          dm_rdata  = mem_rd;
        end
        default: ;
      endcase

      // A new grant may overlap the response delivered above.
      if (if_req && (!dm_req || fetch_at_limit)) begin
        if_gnt          = 1'b1;
        mem_addr        = if_addr;
        resp_state_next = RESP_IF;
      end else if (dm_req) begin
        // A rejected request still occupies the slot, so fetch loses too.
        if (is_misaligned(dm_addr[1:0])) begin
          dm_err = 1'b1;
        end else begin
          dm_gnt   = 1'b1;
          mem_addr = dm_addr;
          mem_wd   = dm_wdata;
          mem_we   = dm_we;
          if (!dm_we) begin
            resp_state_next = RESP_DM;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  int tests = 0;
  int fails = 0;
  int prev;          // owner of the read granted last cycle: 0 none, 1 fetch, 2 data
  logic exp_if;
  logic [31:0] rd_val;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .dm_err    (dm_err),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".if_gnt"},    {31'd0, if_gnt},    32'd0);
    chk({tag, ".if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
    chk({tag, ".if_rdata"},  if_rdata,           32'd0);
    chk({tag, ".dm_gnt"},    {31'd0, dm_gnt},    32'd0);
    chk({tag, ".dm_rvalid"}, {31'd0, dm_rvalid}, 32'd0);
    chk({tag, ".dm_rdata"},  dm_rdata,           32'd0);
    chk({tag, ".dm_err"},    {31'd0, dm_err},    32'd0);
    chk({tag, ".mem_addr"},  mem_addr,           32'd0);
    chk({tag, ".mem_wd"},    mem_wd,             32'd0);
    chk({tag, ".mem_we"},    {31'd0, mem_we},    32'd0);
  endtask

  // Response checks for the read granted in the previous cycle (prev).
  task automatic chk_resp(input string tag, input int owner, input logic [31:0] data);
    chk({tag, ".if_rvalid"}, {31'd0, if_rvalid}, {31'd0, owner == 1});
    chk({tag, ".dm_rvalid"}, {31'd0, dm_rvalid}, {31'd0, owner == 2});
    chk({tag, ".if_rdata"},  if_rdata, (owner == 1) ? data : 32'd0);
    chk({tag, ".dm_rdata"},  dm_rdata, (owner == 2) ? data : 32'd0);
    chk({tag, ".one_rvalid"}, {31'd0, if_rvalid & dm_rvalid}, 32'd0);
  endtask

  initial begin
    // Reset with requests pending: every output must stay low.
    rst      = 1'b1;
    if_req   = 1'b1;
    if_addr  = 32'h10;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h20;
    dm_wdata = 32'h55;
    mem_rd   = 32'h1234;
    @(negedge clk);
    chk_all_zero("reset");
    tick();
    rst    = 1'b0;
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
    chk_all_zero("idle");

    // Fetch read, response one cycle later.
    tick();
    if_req  = 1'b1;
    if_addr = 32'h10;
    mem_rd  = 32'h0;
    @(negedge clk);
    chk("fetch.if_gnt",   {31'd0, if_gnt}, 32'd1);
    chk("fetch.dm_gnt",   {31'd0, dm_gnt}, 32'd0);
    chk("fetch.mem_addr", mem_addr, 32'h10);
    chk("fetch.mem_we",   {31'd0, mem_we}, 32'd0);
    chk("fetch.mem_wd",   mem_wd, 32'd0);
    tick();
    if_req = 1'b0;
    mem_rd = 32'h00500093;
    @(negedge clk);
    chk_resp("fetch.resp", 1, 32'h00500093);
    chk("fetch.resp.mem_addr", mem_addr, 32'd0);

    // Store: command this cycle, no response next cycle.
    tick();
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h20;
    dm_wdata = 32'hDEADBEEF;
    mem_rd   = 32'h0;
    @(negedge clk);
    chk("store.dm_gnt",   {31'd0, dm_gnt}, 32'd1);
    chk("store.mem_we",   {31'd0, mem_we}, 32'd1);
    chk("store.mem_addr", mem_addr, 32'h20);
    chk("store.mem_wd",   mem_wd, 32'hDEADBEEF);
    chk("store.if_rvalid", {31'd0, if_rvalid}, 32'd0);
    tick();
    dm_req = 1'b0;
    mem_rd = 32'h11111111;
    @(negedge clk);
    chk_resp("store.resp", 0, 32'h11111111);

    // Misaligned load with fetch pending: rejection consumes the slot.
    tick();
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h22;
    if_req  = 1'b1;
    if_addr = 32'h44;
    @(negedge clk);
    chk("misal.dm_err",   {31'd0, dm_err}, 32'd1);
    chk("misal.dm_gnt",   {31'd0, dm_gnt}, 32'd0);
    chk("misal.if_gnt",   {31'd0, if_gnt}, 32'd0);
    chk("misal.mem_we",   {31'd0, mem_we}, 32'd0);
    chk("misal.mem_addr", mem_addr, 32'd0);
    tick();
    dm_req = 1'b0;
    mem_rd = 32'h22222222;
    @(negedge clk);
    chk_resp("misal.resp", 0, 32'h22222222);
    chk("misal.err_pulse", {31'd0, dm_err}, 32'd0);
    chk("misal.fetch_gnt", {31'd0, if_gnt}, 32'd1);
    chk("misal.fetch_addr", mem_addr, 32'h44);
    prev = 1;

    // Both requesting continuously: four data loads, then one fetch.
    for (int k = 0; k < 10; k++) begin
      tick();
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = 32'h40;
      if_addr = 32'h80;
      rd_val  = 32'hA0000000 + k;
      mem_rd  = rd_val;
      @(negedge clk);
      exp_if = ((k % 5) == 4);
      chk($sformatf("starve%0d.if_gnt", k), {31'd0, if_gnt}, {31'd0, exp_if});
      chk($sformatf("starve%0d.dm_gnt", k), {31'd0, dm_gnt}, {31'd0, !exp_if});
      chk($sformatf("starve%0d.mem_addr", k), mem_addr, exp_if ? 32'h80 : 32'h40);
      chk_resp($sformatf("starve%0d", k), prev, rd_val);
      prev = exp_if ? 1 : 2;
    end

    // Alternating fetch and load grants.
    for (int k = 0; k < 6; k++) begin
      tick();
      if_req  = (k % 2) == 0;
      dm_req  = (k % 2) == 1;
      dm_we   = 1'b0;
      dm_addr = 32'h100 + 4 * k;
      if_addr = 32'h400 + 4 * k;
      rd_val  = 32'hB0000000 + k;
      mem_rd  = rd_val;
      @(negedge clk);
      chk($sformatf("alt%0d.if_gnt", k), {31'd0, if_gnt}, {31'd0, (k % 2) == 0});
      chk($sformatf("alt%0d.dm_gnt", k), {31'd0, dm_gnt}, {31'd0, (k % 2) == 1});
      chk_resp($sformatf("alt%0d", k), prev, rd_val);
      prev = ((k % 2) == 0) ? 1 : 2;
    end
    tick();
    if_req = 1'b0;
    dm_req = 1'b0;
    mem_rd = 32'hC0C0C0C0;
    @(negedge clk);
    chk_resp("alt_end", prev, 32'hC0C0C0C0);

    // Load granted, then reset before the response edge.
    tick();
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h200;
    mem_rd  = 32'h0;
    @(negedge clk);
    chk("rstmid.dm_gnt", {31'd0, dm_gnt}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("rstmid.held");
    tick();
    rst    = 1'b0;
    dm_req = 1'b0;
    mem_rd = 32'hDDDDDDDD;
    #1;
    chk_resp("rstmid.release", 0, 32'hDDDDDDDD);
    @(negedge clk);
    chk_resp("rstmid.release_neg", 0, 32'hDDDDDDDD);

    // Arbiter resumes normally after reset.
    tick();
    dm_req  = 1'b1;
    dm_addr = 32'h300;
    @(negedge clk);
    chk("post.dm_gnt", {31'd0, dm_gnt}, 32'd1);
    tick();
    dm_req = 1'b0;
    mem_rd = 32'h12345678;
    @(negedge clk);
    chk_resp("post.resp", 2, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
